// File: rtl/clk_div_prog.sv
// Run-time programmable clock divider / clock-enable generator on clock_100.
// Ratio changes are staged and applied only at a period wrap, so clk_out never runts.
module clk_div_prog #(
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned DIV_RESET = 12
) (
  input  logic             clock_100,
  input  logic             resetn,
  input  logic             en,
  input  logic [CNT_W-1:0] div_in,
  input  logic             div_load,
  output logic             div_busy,
  output logic [CNT_W-1:0] div_active,
  output logic             clk_out,
  output logic             tick
);

  localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DIV_RESET);
  localparam logic [CNT_W-1:0] DIV_MIN = CNT_W'(2);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] pending;
  logic [CNT_W-1:0] div_clamped;
  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W-1:0] div_nxt;
  logic             wrap;

  // clk_out is computed from the post-edge count and ratio so it always matches cnt >= D/2.
  always_comb begin
    div_clamped = (div_in < DIV_MIN) ? DIV_MIN : div_in;
    wrap        = en && (cnt == div_active - CNT_W'(1));
    cnt_nxt     = cnt;
    div_nxt     = div_active;
    if (en) begin
      cnt_nxt = wrap ? '0 : cnt + CNT_W'(1);
    end
    if (wrap && div_load) begin
      div_nxt = div_clamped;
    end else if (wrap && div_busy) begin
      div_nxt = pending;
    end
  end

  always_ff @(posedge clock_100) begin
    if (!resetn) begin
      cnt        <= '0;
      pending    <= '0;
      div_busy   <= 1'b0;
      div_active <= DIV_RST;
      clk_out    <= 1'b0;
      tick       <= 1'b0;
    end else begin
      cnt        <= cnt_nxt;
      div_active <= div_nxt;
      clk_out    <= (cnt_nxt >= (div_nxt >> 1));
      tick       <= wrap;
      if (wrap) begin
        div_busy <= 1'b0;
      end else if (div_load) begin
        pending  <= div_clamped;
        div_busy <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_clk_div_prog.sv
// Self-checking bench for clk_div_prog: directed table, corner sequences and
// randomized traffic against a period-position reference model.
module tb_clk_div_prog;

  logic       clock_100 = 1'b0;
  logic       resetn    = 1'b0;
  logic       en        = 1'b0;
  logic [7:0] div_in    = '0;
  logic       div_load  = 1'b0;
  logic       div_busy;
  logic [7:0] div_active;
  logic       clk_out;
  logic       tick;

  int n_chk = 0;
  int n_err = 0;

  // reference model: position within the period, active ratio, staged ratio
  int m_pos  = 0;
  int m_d    = 12;
  int m_pend = 0;
  bit m_busy = 0;
  bit m_tick = 0;

  clk_div_prog #(.CNT_W(8), .DIV_RESET(12)) dut (
    .clock_100 (clock_100),
    .resetn    (resetn),
    .en        (en),
    .div_in    (div_in),
    .div_load  (div_load),
    .div_busy  (div_busy),
    .div_active(div_active),
    .clk_out   (clk_out),
    .tick      (tick)
  );

  always #5 clock_100 = ~clock_100;

  typedef struct {
    logic       rst_n;
    logic       en;
    logic [7:0] din;
    logic       ld;
    int         n;
    logic       busy;
    logic [7:0] act;
    logic       clk;
    logic       tck;
  } vec_t;

  vec_t tbl[14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int clampv(input int v);
    return (v < 2) ? 2 : v;
  endfunction

  task automatic model_edge(input bit r, input bit e, input int d, input bit l);
    if (!r) begin
      m_pos = 0; m_d = 12; m_pend = 0; m_busy = 0; m_tick = 0;
    end else begin
      m_tick = 0;
      if (e && m_pos == m_d - 1) begin
        m_pos  = 0;
        m_tick = 1;
        if (l) m_d = clampv(d);
        else if (m_busy) m_d = m_pend;
        m_busy = 0;
      end else begin
        if (e) m_pos = m_pos + 1;
        if (l) begin m_pend = clampv(d); m_busy = 1; end
      end
    end
  endtask

  // drive, clock once, then compare every output with the model
  task automatic step(input logic r, input logic e, input logic [7:0] d, input logic l);
    resetn = r; en = e; div_in = d; div_load = l;
    @(posedge clock_100);
    model_edge(r, e, int'(d), l);
    #1;
    chk("m_busy",   {31'b0, div_busy}, {31'b0, m_busy});
    chk("m_active", {24'b0, div_active}, m_d);
    chk("m_clk",    {31'b0, clk_out}, {31'b0, (m_pos >= m_d / 2)});
    chk("m_tick",   {31'b0, tick}, {31'b0, m_tick});
  endtask

  initial begin
    bit q[$];
    int run, minrun, nruns;

    // ---- table-driven vectors: inputs held for n edges, then outputs compared
    tbl[0]  = '{1'b0, 1'b0, 8'd0,   1'b0, 1,   1'b0, 8'd12,  1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 8'd3,   1'b1, 1,   1'b1, 8'd12,  1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 8'd0,   1'b0, 5,   1'b1, 8'd12,  1'b1, 1'b0};
    tbl[3]  = '{1'b1, 1'b1, 8'd0,   1'b0, 5,   1'b1, 8'd12,  1'b1, 1'b0};
    tbl[4]  = '{1'b1, 1'b1, 8'd0,   1'b0, 1,   1'b0, 8'd3,   1'b0, 1'b1};
    tbl[5]  = '{1'b1, 1'b1, 8'd0,   1'b0, 1,   1'b0, 8'd3,   1'b1, 1'b0};
    tbl[6]  = '{1'b1, 1'b1, 8'd0,   1'b0, 1,   1'b0, 8'd3,   1'b1, 1'b0};
    tbl[7]  = '{1'b1, 1'b1, 8'd0,   1'b0, 1,   1'b0, 8'd3,   1'b0, 1'b1};
    tbl[8]  = '{1'b1, 1'b0, 8'd1,   1'b1, 1,   1'b1, 8'd3,   1'b0, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 8'd0,   1'b0, 3,   1'b1, 8'd3,   1'b0, 1'b0};
    tbl[10] = '{1'b1, 1'b1, 8'd0,   1'b0, 2,   1'b1, 8'd3,   1'b1, 1'b0};
    tbl[11] = '{1'b1, 1'b1, 8'd200, 1'b1, 1,   1'b0, 8'd200, 1'b0, 1'b1};
    tbl[12] = '{1'b1, 1'b1, 8'd0,   1'b0, 100, 1'b0, 8'd200, 1'b1, 1'b0};
    tbl[13] = '{1'b0, 1'b1, 8'd0,   1'b0, 1,   1'b0, 8'd12,  1'b0, 1'b0};

    for (int i = 0; i < 14; i++) begin
      for (int k = 0; k < tbl[i].n; k++) step(tbl[i].rst_n, tbl[i].en, tbl[i].din, tbl[i].ld);
      chk($sformatf("tbl%0d_busy", i),   {31'b0, div_busy},   {31'b0, tbl[i].busy});
      chk($sformatf("tbl%0d_active", i), {24'b0, div_active}, {24'b0, tbl[i].act});
      chk($sformatf("tbl%0d_clk", i),    {31'b0, clk_out},    {31'b0, tbl[i].clk});
      chk($sformatf("tbl%0d_tick", i),   {31'b0, tick},       {31'b0, tbl[i].tck});
    end

    // ---- default ratio: 6 low / 6 high, first tick 12 edges after release
    step(1'b0, 1'b0, 8'd0, 1'b0);
    for (int i = 1; i <= 24; i++) begin
      step(1'b1, 1'b1, 8'd0, 1'b0);
      chk("d12_tick", {31'b0, tick}, {31'b0, (i % 12 == 0)});
      chk("d12_clk",  {31'b0, clk_out}, {31'b0, ((i % 12) >= 6)});
    end

    // ---- load 5 mid-period: busy until the wrap, no runt pulse at the switch
    step(1'b0, 1'b0, 8'd0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 8'd0, 1'b0);
    step(1'b1, 1'b1, 8'd5, 1'b1);
    q.delete();
    for (int i = 0; i < 30; i++) begin
      step(1'b1, 1'b1, 8'd0, 1'b0);
      q.push_back(clk_out);
      if (i == 6) chk("d5_busy_before_wrap", {31'b0, div_busy}, 32'd1);
      if (i == 7) chk("d5_active_after_wrap", {24'b0, div_active}, 32'd5);
    end
    run = 1; minrun = 1000; nruns = 0;
    for (int i = 1; i < q.size(); i++) begin
      if (q[i] == q[i-1]) run++;
      else begin
        if (nruns > 0 && run < minrun) minrun = run;
        nruns++;
        run = 1;
      end
    end
    chk("d5_min_pulse_ge2", {31'b0, (minrun >= 2)}, 32'd1);

    // ---- clamp: 0 and 1 both give ratio 2
    for (int v = 0; v < 2; v++) begin
      step(1'b0, 1'b0, 8'd0, 1'b0);
      step(1'b1, 1'b1, 8'(v), 1'b1);
      for (int i = 0; i < 14; i++) step(1'b1, 1'b1, 8'd0, 1'b0);
      chk($sformatf("clamp%0d_active", v), {24'b0, div_active}, 32'd2);
    end

    // ---- 7 then 9 before the wrap: 9 wins, busy drops at that wrap
    step(1'b0, 1'b0, 8'd0, 1'b0);
    step(1'b1, 1'b1, 8'd7, 1'b1);
    step(1'b1, 1'b1, 8'd9, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 8'd0, 1'b0);
    chk("last_load_active", {24'b0, div_active}, 32'd9);
    chk("last_load_busy",   {31'b0, div_busy}, 32'd0);

    // ---- en low for 10 cycles at cnt=4; period finishes after 8 more enabled edges
    step(1'b0, 1'b0, 8'd0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 8'd0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0, 8'd0, 1'b0);
      chk("hold_tick", {31'b0, tick}, 32'd0);
      chk("hold_clk",  {31'b0, clk_out}, 32'd0);
    end
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 1'b1, 8'd0, 1'b0);
      chk("resume_tick", {31'b0, tick}, {31'b0, (i == 8)});
    end

    // ---- reset with a pending ratio at cnt=9
    step(1'b0, 1'b0, 8'd0, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 8'd0, 1'b0);
    step(1'b1, 1'b1, 8'd5, 1'b1);
    step(1'b0, 1'b1, 8'd0, 1'b0);
    chk("rst_busy",   {31'b0, div_busy}, 32'd0);
    chk("rst_active", {24'b0, div_active}, 32'd12);
    chk("rst_clk",    {31'b0, clk_out}, 32'd0);
    for (int i = 0; i < 12; i++) step(1'b1, 1'b1, 8'd0, 1'b0);
    chk("rst_discard_pending", {24'b0, div_active}, 32'd12);

    // ---- randomized traffic against the model
    step(1'b0, 1'b0, 8'd0, 1'b0);
    for (int i = 0; i < 2000; i++) begin
      logic       r, e, l;
      logic [7:0] d;
      r = ($urandom_range(0, 99) != 0);
      e = ($urandom_range(0, 3) != 0);
      l = ($urandom_range(0, 9) == 0);
      d = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 6)) : 8'($urandom_range(0, 40));
      step(r, e, d, l);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got running want done");
    $fatal(1);
  end

endmodule

// File: doc/clk_div_prog.md
Name: clk_div_prog

Overview:
- Run-time programmable clock divider and clock-enable generator; successor to the fixed divide-by-12 divider.
- Produces a divided square wave clk_out and a one-cycle tick strobe from clock_100.
- Divide ratio is a full-period value of 2..2^CNT_W-1, parametrised in width and reset value.
- New ratios are loaded through a strobe and applied glitch-free at the next period boundary. Feeds processor/memory timing logic that needs a slower clock or enable.

Parameters:
- CNT_W, 8, width of divisor and period counter.
- DIV_RESET, 12, divide ratio active after reset (12 gives 100 MHz -> 8.33 MHz); must be 2..2^CNT_W-1.

Ports:
- clock_100  input  1  system clock, all logic on its rising edge.
- resetn  input  1  synchronous reset, active-low.
- en  input  1  count enable; low freezes the divider.
- div_in  input  CNT_W  requested full-period divide ratio.
- div_load  input  1  one-cycle strobe; captures div_in into the pending register.
- div_busy  output  1  high while a captured ratio is pending (not yet applied).
- div_active  output  CNT_W  ratio currently in use, D.
- clk_out  output  1  divided clock, registered.
- tick  output  1  one-cycle pulse per period, registered.

Behaviour:
- One clock; reset is synchronous and active-low.
- Reset (resetn=0 at a clock_100 edge): cnt=0, clk_out=0, tick=0, div_busy=0, pending=0, div_active=DIV_RESET. Reset mid-period discards the pending ratio and restarts the phase.
- Counter: cnt runs 0..D-1.
  - On each enabled edge: if cnt==D-1, cnt<=0; else cnt<=cnt+1.
- Duty: L = D>>1 (floor). clk_out is registered so that it always equals (cnt >= L) for the current cnt.
  - Low for L cycles, high for D-L cycles; odd D is high one cycle longer.
  - Falling edge occurs exactly at the wrap.
- tick: 1 for exactly the cycle following a wrap edge, i.e. while cnt==0 after a wrap. It is not asserted after reset. It is 0 in every other cycle, including all disabled cycles.
- en=0: cnt, clk_out and div_active hold; tick=0. div_load is still accepted.
- Ratio load: div_load=1 captures clamp(div_in) into pending and sets div_busy the next cycle.
  - clamp: a value below 2 becomes 2.
  - A load while busy overwrites pending; the last value wins.
- Apply: on the wrap edge (cnt==D-1, en=1) with div_busy=1:
  - div_active<=pending, div_busy<=0, cnt<=0.
  - The new L/D take effect from cnt==0 onward. No runt pulses: clk_out is already 0 at the wrap.
- Simultaneous div_load and wrap edge: the newly presented div_in is applied at this wrap, and div_busy stays 0.
- Width: all compares are done at CNT_W bits. D-1 never underflows because D>=2.

Test Plan:
- Reset then en=1, default D=12: clk_out low 6 cycles and high 6; tick pulses every 12 cycles; first tick 12 edges after reset release.
- div_in=5 with div_load mid-period: div_busy=1 until the next wrap; then div_active=5, clk_out low 2 / high 3, tick every 5 cycles, and no clk_out pulse shorter than 2 cycles at the switch.
- div_in=0 and div_in=1 loads: div_active becomes 2, clk_out alternates 1 low / 1 high, tick every 2 cycles.
- Loads of 7 then 9 before a wrap: only 9 is applied, and div_busy drops at that wrap.
- Drop en for 10 cycles at cnt=4, D=12: cnt, clk_out hold and tick=0; on resume the period completes with 8 more enabled cycles.
- Assert resetn=0 for 1 cycle with a pending ratio at cnt=9: next cycle cnt=0, clk_out=0, div_busy=0, div_active=12.
